pipeline_ctrl: RTL and testbench

// - Central stall/flush sequencer for the 5-stage MIPS pipe (IF, ID, EX, MEM, WB).
// - Merges hazard sources into per-register stall/flush controls: load-use, branch-in-ID

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 35 +++
 rtl/pipeline_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   pipe_state_t : sequencer FSM encoding (RUN, MDU_BUSY, DMEM_WAIT)
//   REG_ZERO     : index of the hard-wired zero register, which never carries a dependency
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU_BUSY  = 2'd1,
        DMEM_WAIT = 2'd2
    } pipe_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational data-hazard compare between the instruction in EX
// and the source registers of the instruction in ID.
// Ports:
//   id_rs, id_rt  in   source registers of the ID instruction
//   id_branch     in   ID instruction compares its operands in ID (branch / jr)
//   ex_memread    in   EX holds a load
//   ex_regwrite   in   EX writes a GPR
//   ex_rd         in   EX destination register
//   hz_stall      out  load-use or branch-operand dependency present
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_branch,
    input  logic            ex_memread,
    input  logic            ex_regwrite,
    input  logic [RA_W-1:0] ex_rd,
    output logic            hz_stall
);

    logic rd_nonzero;
    logic rd_match;

    assign rd_nonzero = (ex_rd != RA_W'(REG_ZERO));
    assign rd_match   = (ex_rd == id_rs) || (ex_rd == id_rt);

    // A load result is not available until after MEM; a branch compares in ID,
    // so any ALU result still in EX is also too late for it.
    assign hz_stall = rd_nonzero && rd_match &&
                      (ex_memread || (id_branch && ex_regwrite));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipe (IF, ID, EX, MEM, WB).
// Merges exception, data-memory wait, multi-cycle MDU, data hazards, taken
// branches and fetch wait into hold (stall_*) and bubble (flush_*) controls for
// the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and owns MDU start/cancel.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs, id_rt, id_branch, id_taken       ID-stage information
//   ex_memread, ex_regwrite, ex_rd, ex_mdu_op  EX-stage information
//   mdu_done                   MDU result valid pulse
//   if_req/if_ready, mem_req/mem_ready      fetch and data memory handshakes
//   exc_valid                  exception / eret committed in MEM
//   stall_*, flush_*           per-register hold / bubble controls
//   mdu_start, mdu_cancel      one-cycle MDU launch / abort pulses
//   ctrl_busy                  sequencer is not in RUN
//   perf_stall_cyc, perf_flush_cnt  saturating counters (only with PIPE_PERF_CNT_EN)
//   state_dbg                  current FSM state
// Configuration: define PIPE_PERF_CNT_EN to add the performance counters.
//
// Handshakes: a memory access is outstanding while req = 1 and ready = 0; the
// cycle in which ready = 1 completes it. mdu_start launches one operation; the
// operation completes on the cycle mdu_done = 1 (a done seen in the launch cycle
// belongs to nothing and is ignored), or is abandoned by mdu_cancel.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_branch,
    input  logic             id_taken,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_mdu_op,
    input  logic             mdu_done,
    input  logic             if_req,
    input  logic             if_ready,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             exc_valid,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             mdu_start,
    output logic             mdu_cancel,
    output logic             ctrl_busy,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt,
`endif
    output logic [1:0]       state_dbg
);

    pipe_state_t state, state_nxt;
    logic        hz_stall;
    logic        flush_event;

    hazard_detect #(.RA_W(RA_W)) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_branch   (id_branch),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .ex_rd       (ex_rd),
        .hz_stall    (hz_stall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        mdu_start    = 1'b0;
        mdu_cancel   = 1'b0;
        flush_event  = 1'b0;
        if (!rst_n) begin
            // Hold the pipe empty while in reset.
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (exc_valid) begin
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        flush_event  = 1'b1;
                    end else if (mem_req && !mem_ready) begin
                        // A pending mdu op in EX waits here; it launches once back in RUN.
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        flush_mem_wb = 1'b1;
                        state_nxt    = DMEM_WAIT;
                    end else if (ex_mdu_op) begin
                        mdu_start    = 1'b1;
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        state_nxt    = MDU_BUSY;
                    end else begin
                        if (hz_stall) begin
                            stall_pc    = 1'b1;
                            stall_if_id = 1'b1;
                            flush_id_ex = 1'b1;
                        end else if (id_taken) begin
                            flush_if_id = 1'b1;
                            flush_event = 1'b1;
                        end
                        // Fetch wait only matters when nothing above already holds the PC.
                        if (!hz_stall && if_req && !if_ready) begin
                            stall_pc    = 1'b1;
                            flush_if_id = 1'b1;
                        end
                    end
                end
                MDU_BUSY: begin
                    if (exc_valid) begin
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        mdu_cancel   = 1'b1;
                        flush_event  = 1'b1;
                        state_nxt    = RUN;
                    end else if (!mdu_done) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                DMEM_WAIT: begin
                    // The exception source holds exc_valid until MEM can accept it.
                    if (!mem_ready) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        flush_mem_wb = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign ctrl_busy = (state != RUN);
    assign state_dbg = state;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_pc && (perf_stall_cyc != {CNT_W{1'b1}}))
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if (flush_event && (perf_flush_cnt != {CNT_W{1'b1}}))
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`else
    logic unused_flush_event;
    assign unused_flush_event = flush_event;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. Inputs change 1 ns after the rising
// edge; combinational outputs are sampled 3 ns after the rising edge.
// ctl packs the outputs as {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
// stall_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
// mdu_start, mdu_cancel, ctrl_busy}.
module tb_pipeline_ctrl;

    localparam logic [11:0] C_IDLE     = 12'b00000_0000_000;
    localparam logic [11:0] C_RST      = 12'b00000_1111_000;
    localparam logic [11:0] C_HZ       = 12'b11000_0100_000;
    localparam logic [11:0] C_TAKEN    = 12'b00000_1000_000;
    localparam logic [11:0] C_IFW      = 12'b10000_1000_000;
    localparam logic [11:0] C_MDU_GO   = 12'b11100_0010_100;
    localparam logic [11:0] C_MDU_WAIT = 12'b11100_0010_001;
    localparam logic [11:0] C_BUSY_END = 12'b00000_0000_001;
    localparam logic [11:0] C_DM_RUN   = 12'b11110_0001_000;
    localparam logic [11:0] C_DM_WAIT  = 12'b11110_0001_001;
    localparam logic [11:0] C_EXC_MDU  = 12'b00000_1110_011;
    localparam logic [11:0] C_EXC_RUN  = 12'b00000_1110_000;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_branch, id_taken, ex_memread, ex_regwrite, ex_mdu_op, mdu_done;
    logic if_req, if_ready, mem_req, mem_ready, exc_valid;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic mdu_start, mdu_cancel, ctrl_busy;
    logic [1:0] state_dbg;
    logic [11:0] ctl;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch), .id_taken(id_taken),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .ex_mdu_op(ex_mdu_op), .mdu_done(mdu_done),
        .if_req(if_req), .if_ready(if_ready), .mem_req(mem_req), .mem_ready(mem_ready),
        .exc_valid(exc_valid),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
        .mdu_start(mdu_start), .mdu_cancel(mdu_cancel), .ctrl_busy(ctrl_busy),
        .state_dbg(state_dbg)
    );

    assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
                  mdu_start, mdu_cancel, ctrl_busy};

    // driver tasks
    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_branch = 1'b0; id_taken = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0;
        ex_mdu_op = 1'b0; mdu_done = 1'b0; if_req = 1'b0; if_ready = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; exc_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        set_idle();
        exc_valid = 1'b1; ex_mdu_op = 1'b1;
        settle();
        if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", ctl, C_RST); end
        n_tests++;
        next_cycle();
        rst_n = 1'b1;
        set_idle();
        settle();
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_release: got %b want %b", ctl, C_IDLE); end
        n_tests++;
        if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        n_tests++;
    endtask

    task automatic test_load_use();
        next_cycle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
        settle();
        if (ctl !== C_HZ) begin n_fail++; $display("FAIL load_use_rs: got %b want %b", ctl, C_HZ); end
        n_tests++;
        next_cycle();
        ex_rd = 5'd9; id_rs = 5'd1;
        settle();
        if (ctl !== C_HZ) begin n_fail++; $display("FAIL load_use_rt: got %b want %b", ctl, C_HZ); end
        n_tests++;
        next_cycle();
        ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        settle();
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL load_use_r0: got %b want %b", ctl, C_IDLE); end
        n_tests++;
        next_cycle();
        ex_rd = 5'd6; id_rs = 5'd5; id_rt = 5'd7;
        settle();
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL load_use_nomatch: got %b want %b", ctl, C_IDLE); end
        n_tests++;
        set_idle();
    endtask

    task automatic test_branch_dep();
        next_cycle();
        id_branch = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_taken = 1'b1;
        settle();
        if (ctl !== C_HZ) begin n_fail++; $display("FAIL branch_dep_stall: got %b want %b", ctl, C_HZ); end
        n_tests++;
        next_cycle();
        ex_regwrite = 1'b0; ex_rd = 5'd0;
        settle();
        if (ctl !== C_TAKEN) begin n_fail++; $display("FAIL branch_taken_after: got %b want %b", ctl, C_TAKEN); end
        n_tests++;
        next_cycle();
        id_branch = 1'b0; id_taken = 1'b0; ex_regwrite = 1'b1; ex_rd = 5'd8;
        settle();
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL alu_no_branch: got %b want %b", ctl, C_IDLE); end
        n_tests++;
        set_idle();
    endtask

    task automatic test_if_wait();
        next_cycle();
        if_req = 1'b1; if_ready = 1'b0;
        settle();
        if (ctl !== C_IFW) begin n_fail++; $display("FAIL if_wait: got %b want %b", ctl, C_IFW); end
        n_tests++;
        next_cycle();
        ex_memread = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
        settle();
        if (ctl !== C_HZ) begin n_fail++; $display("FAIL if_wait_under_hz: got %b want %b", ctl, C_HZ); end
        n_tests++;
        next_cycle();
        set_idle();
        if_req = 1'b1; if_ready = 1'b1;
        settle();
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL if_ready: got %b want %b", ctl, C_IDLE); end
        n_tests++;
        set_idle();
    endtask

    task automatic test_mdu();
        next_cycle();
        ex_mdu_op = 1'b1; mdu_done = 1'b1;
        settle();
        if (ctl !== C_MDU_GO) begin n_fail++; $display("FAIL mdu_start_cycle: got %b want %b", ctl, C_MDU_GO); end
        n_tests++;
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            mdu_done = 1'b0;
            settle();
            if (ctl !== C_MDU_WAIT) begin n_fail++; $display("FAIL mdu_wait_%0d: got %b want %b", i, ctl, C_MDU_WAIT); end
            n_tests++;
        end
        if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL mdu_state: got %0d want 1", state_dbg); end
        n_tests++;
        next_cycle();
        mdu_done = 1'b1;
        settle();
        if (ctl !== C_BUSY_END) begin n_fail++; $display("FAIL mdu_done: got %b want %b", ctl, C_BUSY_END); end
        n_tests++;
        next_cycle();
        set_idle();
        settle();
        if (ctl !== C_IDLE || state_dbg !== 2'd0) begin n_fail++; $display("FAIL mdu_back_run: got %b st %0d want %b st 0", ctl, state_dbg, C_IDLE); end
        n_tests++;
    endtask

    task automatic test_dmem();
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0; ex_mdu_op = 1'b1;
        settle();
        if (ctl !== C_DM_RUN) begin n_fail++; $display("FAIL dmem_first: got %b want %b", ctl, C_DM_RUN); end
        n_tests++;
        next_cycle();
        settle();
        if (ctl !== C_DM_WAIT || state_dbg !== 2'd2) begin n_fail++; $display("FAIL dmem_wait: got %b st %0d want %b st 2", ctl, state_dbg, C_DM_WAIT); end
        n_tests++;
        next_cycle();
        exc_valid = 1'b1;
        settle();
        if (ctl !== C_DM_WAIT) begin n_fail++; $display("FAIL dmem_exc_ignored: got %b want %b", ctl, C_DM_WAIT); end
        n_tests++;
        next_cycle();
        exc_valid = 1'b0; mem_ready = 1'b1;
        settle();
        if (ctl !== C_BUSY_END) begin n_fail++; $display("FAIL dmem_ready: got %b want %b", ctl, C_BUSY_END); end
        n_tests++;
        next_cycle();
        mem_req = 1'b0; mem_ready = 1'b0;
        settle();
        if (ctl !== C_MDU_GO) begin n_fail++; $display("FAIL dmem_deferred_start: got %b want %b", ctl, C_MDU_GO); end
        n_tests++;
        next_cycle();
        mdu_done = 1'b1;
        settle();
        if (ctl !== C_BUSY_END) begin n_fail++; $display("FAIL dmem_mdu_done: got %b want %b", ctl, C_BUSY_END); end
        n_tests++;
        next_cycle();
        set_idle();
    endtask

    task automatic test_exception();
        next_cycle();
        ex_mdu_op = 1'b1;
        settle();
        if (ctl !== C_MDU_GO) begin n_fail++; $display("FAIL exc_mdu_start: got %b want %b", ctl, C_MDU_GO); end
        n_tests++;
        next_cycle();
        exc_valid = 1'b1;
        settle();
        if (ctl !== C_EXC_MDU) begin n_fail++; $display("FAIL exc_cancel: got %b want %b", ctl, C_EXC_MDU); end
        n_tests++;
        next_cycle();
        set_idle();
        settle();
        if (ctl !== C_IDLE || state_dbg !== 2'd0) begin n_fail++; $display("FAIL exc_back_run: got %b st %0d want %b st 0", ctl, state_dbg, C_IDLE); end
        n_tests++;
        next_cycle();
        exc_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_taken = 1'b1;
        settle();
        if (ctl !== C_EXC_RUN) begin n_fail++; $display("FAIL exc_over_hz: got %b want %b", ctl, C_EXC_RUN); end
        n_tests++;
        set_idle();
    endtask

    task automatic test_reset_mid_mdu();
        next_cycle();
        ex_mdu_op = 1'b1;
        next_cycle();
        settle();
        if (ctl !== C_MDU_WAIT) begin n_fail++; $display("FAIL rst_mdu_busy: got %b want %b", ctl, C_MDU_WAIT); end
        n_tests++;
        rst_n = 1'b0;
        #1;
        if (ctl !== C_RST || state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_mid_mdu: got %b st %0d want %b st 0", ctl, state_dbg, C_RST); end
        n_tests++;
        next_cycle();
        set_idle();
        rst_n = 1'b1;
        settle();
        if (ctl !== C_IDLE || state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_release_run: got %b st %0d want %b st 0", ctl, state_dbg, C_IDLE); end
        n_tests++;
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_branch_dep();
        test_if_wait();
        test_mdu();
        test_dmem();
        test_exception();
        test_reset_mid_mdu();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound on simulated time.
    initial begin
        #20000;
        $display("FAIL timeout: sim time exceeded, tests %0d", n_tests);
        $fatal(1);
    end

endmodule
